// File: rtl/clk_ce_gen.sv
// ============================================================================
// clk_ce_gen
// ----------------------------------------------------------------------------
// Fractional clock-enable generator. Each channel runs an ACC_W-bit phase
// accumulator on refclk. The carry out of every wrapping addition becomes a
// single-cycle pulse on ce[i]. The mean rate is f_refclk * inc[i] / 2^ACC_W.
//
// The accumulators only run once PLL lock has been qualified. pll_locked is
// synchronised first. It must then stay high for LOCK_HOLDOFF consecutive
// refclk cycles. Any loss of lock drops the block back to waiting, clears
// all accumulators and stops every ce output.
//
// Parameters
//   CHANNELS     number of clock-enable channels (1..8)
//   ACC_W        accumulator / increment width (4..32)
//   LOCK_HOLDOFF cycles of stable lock before enabling outputs (>= 2)
//   INC_INIT     increment loaded into every channel at reset
//
// Ports
//   refclk     in   sole clock, all state on its rising edge
//   rst_n      in   asynchronous active-low reset
//   pll_locked in   PLL lock status, asynchronous to refclk
//   phase_rst  in   synchronous strobe, zeroes all accumulators
//   inc_wr     in   increment write strobe
//   inc_sel    in   [2:0] target channel of the increment write
//   inc_data   in   [ACC_W-1:0] new increment value
//   inc_ack    out  one-cycle acknowledge, the cycle after each inc_wr
//   inc_err    out  coincident with inc_ack when inc_sel >= CHANNELS
//   ready      out  high exactly while lock is qualified (RUN state)
//   ce         out  [CHANNELS-1:0] per-channel single-cycle enables
// ============================================================================
module clk_ce_gen #(
    parameter int                 CHANNELS     = 4,
    parameter int                 ACC_W        = 32,
    parameter int                 LOCK_HOLDOFF = 1024,
    parameter logic [ACC_W-1:0]   INC_INIT     = '0
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  phase_rst,
    input  logic                  inc_wr,
    input  logic [2:0]            inc_sel,
    input  logic [ACC_W-1:0]      inc_data,
    output logic                  inc_ack,
    output logic                  inc_err,
    output logic                  ready,
    output logic [CHANNELS-1:0]   ce
);

    localparam int CNT_W = $clog2(LOCK_HOLDOFF);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLDOFF   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Lock synchroniser. pll_locked is not used anywhere else.
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_lock_s;

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its pre-edge value, and r_lock_s really lags r_sync1 by one
    // cycle.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Lock qualification FSM
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold_done;

    assign w_hold_done = (r_cnt == CNT_W'(LOCK_HOLDOFF - 1));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state is defaulted to the current state before the case.
    // Every path then assigns it, and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: begin
                w_next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_next_state = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (!r_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (w_hold_done) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_next_state = ST_RESET;
            end
        endcase
    end

    // The holdoff counter counts only while HOLDOFF persists. It is zeroed
    // whenever the FSM heads to WAIT_LOCK, so a lock glitch restarts it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next_state == ST_WAIT_LOCK) begin
            r_cnt <= '0;
        end else if ((r_state == ST_HOLDOFF) && (w_next_state == ST_HOLDOFF)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ready mirrors the state register, so it is 1 exactly while in RUN.
    logic r_ready;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_RUN);
        end
    end

    assign ready = r_ready;

    // ------------------------------------------------------------------------
    // Increment registers and write handshake
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] r_inc [CHANNELS];
    logic             r_ack;
    logic             r_err;
    logic             w_sel_ok;

    assign w_sel_ok = ({1'b0, inc_sel} < 4'(CHANNELS));

    // NOTE: this small register array is reset on purpose. Every channel
    // must restart from INC_INIT. A large RAM would not be reset this way.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_inc[i] <= INC_INIT;
            end
        end else if (inc_wr && w_sel_ok) begin
            // Decode by comparison so inc_sel never indexes past the array.
            for (int i = 0; i < CHANNELS; i++) begin
                if (inc_sel == 3'(i)) begin
                    r_inc[i] <= inc_data;
                end
            end
        end
    end

    // The handshake is independent of lock state. Every write is
    // acknowledged, including out-of-range writes and back-to-back writes.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= inc_wr;
            r_err <= inc_wr && !w_sel_ok;
        end
    end

    assign inc_ack = r_ack;
    assign inc_err = r_err;

    // ------------------------------------------------------------------------
    // Phase accumulators
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc [CHANNELS];
    logic [ACC_W:0]   w_sum [CHANNELS];
    logic [CHANNELS-1:0] r_ce;
    logic             w_run;

    // Accumulate only while RUN persists. If lock drops in RUN, ce and the
    // accumulators clear on the same edge that leaves RUN, so no partial
    // pulse escapes.
    assign w_run = (r_state == ST_RUN) && r_lock_s;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
        end
    end

    // The accumulators are held at 0 outside RUN, so the first RUN addition
    // starts from a base of 0. An increment of 0 can never carry.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ce <= '0;
        end else if (w_run && !phase_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= w_sum[i][ACC_W-1:0];
                r_ce[i]  <= w_sum[i][ACC_W];
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ce <= '0;
        end
    end

    assign ce = r_ce;

endmodule

// File: tb/tb_clk_ce_gen.sv
// ============================================================================
// tb_clk_ce_gen
// ----------------------------------------------------------------------------
// Self-checking bench for clk_ce_gen. The DUT is configured with
// CHANNELS=4, ACC_W=8, LOCK_HOLDOFF=16 and INC_INIT=0x10.
//
// Coverage:
//   - lock qualification latency, including a lock glitch during HOLDOFF
//   - a table of divide ratios
//   - increment writes, including back-to-back and out-of-range writes
//   - phase alignment after phase_rst
//   - lock loss while running
//   - asynchronous reset while running
// ============================================================================
module tb_clk_ce_gen;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       phase_rst;
    logic       inc_wr;
    logic [2:0] inc_sel;
    logic [7:0] inc_data;
    logic       inc_ack;
    logic       inc_err;
    logic       ready;
    logic [3:0] ce;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side copy of the increment registers (valid writes only).
    logic [7:0] m_inc [4];

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] inc;
        int         cycles;
        int         exp_pulses;
        int         exp_first;   // 0 means no pulse is expected
    } vec_t;

    vec_t vecs [6];

    clk_ce_gen #(
        .CHANNELS    (4),
        .ACC_W       (8),
        .LOCK_HOLDOFF(16),
        .INC_INIT    (8'h10)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .phase_rst (phase_rst),
        .inc_wr    (inc_wr),
        .inc_sel   (inc_sel),
        .inc_data  (inc_data),
        .inc_ack   (inc_ack),
        .inc_err   (inc_err),
        .ready     (ready),
        .ce        (ce)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge(s).
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_ready(input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (ready) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic first_ce(input int ch, input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (ce[ch]) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_write(input int sel, input logic [7:0] data, input int exp_err);
        inc_wr   = 1'b1;
        inc_sel  = 3'(sel);
        inc_data = data;
        tick(1);
        inc_wr = 1'b0;
        check("wr_ack_hi", int'(inc_ack), 1);
        check("wr_err", int'(inc_err), exp_err);
        if (sel < 4) begin
            m_inc[sel] = data;
        end
        tick(1);
        check("wr_ack_lo", int'(inc_ack), 0);
        check("wr_err_lo", int'(inc_err), 0);
    endtask

    task automatic pulse_phase_rst();
        phase_rst = 1'b1;
        tick(1);
        phase_rst = 1'b0;
        check("phase_rst_ce_zero", int'(ce), 0);
    endtask

    initial begin
        int k;
        int cnt [4];
        int first0;
        int first1;

        vecs[0] = '{"div_40", 0, 8'h40, 64,   16,  4};
        vecs[1] = '{"div_80", 0, 8'h80, 64,   32,  2};
        vecs[2] = '{"div_ff", 1, 8'hFF, 256,  255, 2};
        vecs[3] = '{"div_00", 2, 8'h00, 1000, 0,   0};
        vecs[4] = '{"div_01", 3, 8'h01, 256,  1,   256};
        vecs[5] = '{"div_20", 1, 8'h20, 64,   8,   8};

        for (int i = 0; i < 4; i++) m_inc[i] = 8'h10;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        phase_rst  = 1'b0;
        inc_wr     = 1'b0;
        inc_sel    = 3'd0;
        inc_data   = 8'd0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_ready", int'(ready), 0);
        check("rst_ce", int'(ce), 0);
        check("rst_ack", int'(inc_ack), 0);
        check("rst_err", int'(inc_err), 0);

        rst_n = 1'b1;
        tick(5);
        check("unlocked_ready", int'(ready), 0);

        // ---------------- lock with a glitch at HOLDOFF cycle 10 ----------------
        // Lock first rises after edge 0. A low glitch over edge 14 restarts
        // qualification as if lock had risen after edge 14: 14 + 19 = 33.
        pll_locked = 1'b1;
        tick(13);
        check("glitch_pre_ready", int'(ready), 0);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_ready(60, k);
        check("glitch_ready_rise", (k < 0) ? -1 : k + 14, 33);

        // INC_INIT = 0x10 from a base of 0 -> carry on the 16th addition.
        first_ce(0, 40, k);
        check("init_inc_first_ce", k, 16);

        // ---------------- divide-ratio table ----------------
        foreach (vecs[v]) begin
            int c;
            int f;
            do_write(vecs[v].sel, vecs[v].inc, 0);
            pulse_phase_rst();
            c = 0;
            f = 0;
            for (int n = 1; n <= vecs[v].cycles; n++) begin
                tick(1);
                if (ce[vecs[v].sel]) begin
                    c++;
                    if (f == 0) f = n;
                end
            end
            check({vecs[v].name, "_pulses"}, c, vecs[v].exp_pulses);
            check({vecs[v].name, "_first"}, f, vecs[v].exp_first);
        end

        // ---------------- out-of-range write changes nothing ----------------
        do_write(7, 8'h55, 1);
        pulse_phase_rst();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int n = 1; n <= 64; n++) begin
            tick(1);
            for (int i = 0; i < 4; i++) if (ce[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bad_sel_ch%0d", i), cnt[i], (64 * int'(m_inc[i])) / 256);
        end

        // ---------------- back-to-back writes, then phase alignment ----------------
        inc_wr   = 1'b1;
        inc_sel  = 3'd0;
        inc_data = 8'h40;
        tick(1);
        check("b2b_ack_1", int'(inc_ack), 1);
        inc_sel  = 3'd1;
        inc_data = 8'h20;
        tick(1);
        inc_wr = 1'b0;
        check("b2b_ack_2", int'(inc_ack), 1);
        tick(1);
        check("b2b_ack_end", int'(inc_ack), 0);
        m_inc[0] = 8'h40;
        m_inc[1] = 8'h20;
        tick(5);
        pulse_phase_rst();
        first0 = 0;
        first1 = 0;
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            if (ce[0] && first0 == 0) first0 = n;
            if (ce[1] && first1 == 0) first1 = n;
            if (n == 8) check("phase_ch0_period4", int'(ce[0]), 1);
        end
        check("phase_ch0_first", first0, 4);
        check("phase_ch1_first", first1, 8);

        // ---------------- phase_rst coincident with inc write ----------------
        inc_wr    = 1'b1;
        inc_sel   = 3'd0;
        inc_data  = 8'h80;
        phase_rst = 1'b1;
        tick(1);
        inc_wr    = 1'b0;
        phase_rst = 1'b0;
        check("coinc_ack", int'(inc_ack), 1);
        check("coinc_ce_zero", int'(ce), 0);
        m_inc[0] = 8'h80;
        first_ce(0, 10, k);
        check("coinc_first_ce", k, 2);

        // ---------------- lock loss in RUN ----------------
        do_write(2, 8'hFF, 0);
        pll_locked = 1'b0;
        tick(2);
        check("lockloss_ready_still", int'(ready), 1);
        tick(1);
        check("lockloss_ready", int'(ready), 0);
        check("lockloss_ce", int'(ce), 0);
        cnt[0] = 0;
        for (int n = 0; n < 20; n++) begin
            tick(1);
            if (ce != 4'd0) cnt[0]++;
        end
        check("lockloss_no_ce", cnt[0], 0);
        do_write(3, 8'h40, 0);
        pll_locked = 1'b1;
        wait_ready(40, k);
        check("relock_latency", k, 19);
        first_ce(3, 10, k);
        check("inc_kept_after_lockloss", k, 4);

        // ---------------- asynchronous reset mid-RUN ----------------
        inc_wr   = 1'b1;
        inc_sel  = 3'd0;
        inc_data = 8'h33;
        tick(1);
        inc_wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", int'(inc_ack), 0);
        check("async_rst_ready", int'(ready), 0);
        check("async_rst_ce", int'(ce), 0);
        cnt[0] = 0;
        for (int n = 0; n < 3; n++) begin
            tick(1);
            if (ce != 4'd0 || ready) cnt[0]++;
        end
        check("in_rst_quiet", cnt[0], 0);
        rst_n = 1'b1;
        wait_ready(40, k);
        check("post_rst_latency", k, 19);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        first_ce(2, 40, k);
        check("inc_revert_ch2", k, 16);
        check("inc_revert_ch0", int'(ce[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_ce_gen.md
CLK_CE_GEN -- requirements
Module: clk_ce_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent clock-enable channels, range 1..8.
REQ-002 SHALL have parameter ACC_W, default 32: phase-accumulator and increment width in bits, range 4..32.
REQ-003 SHALL have parameter LOCK_HOLDOFF, default 1024: refclk cycles of stable lock required before output is enabled, minimum 2.
REQ-004 SHALL have parameter INC_INIT, default 0: increment loaded into every channel at reset.
REQ-005 SHALL have port refclk, input, 1 bit: sole clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock status, asynchronous to refclk.
REQ-008 SHALL have port phase_rst, input, 1 bit: synchronous strobe that zeroes all accumulators.
REQ-009 SHALL have port inc_wr, input, 1 bit: increment write strobe.
REQ-010 SHALL have port inc_sel, input, 3 bits: target channel for the increment write.
REQ-011 SHALL have port inc_data, input, ACC_W bits: new increment value.
REQ-012 SHALL have port inc_ack, output, 1 bit: one-cycle write acknowledge.
REQ-013 SHALL have port inc_err, output, 1 bit: one-cycle pulse, coincident with inc_ack, flagging an out-of-range inc_sel.
REQ-014 SHALL have port ready, output, 1 bit: high when lock is qualified and enables are running.
REQ-015 SHALL have port ce, output, CHANNELS bits: per-channel single-cycle clock-enable pulses.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer to form lock_s; no other logic uses pll_locked directly.
REQ-017 SHALL implement states RESET, WAIT_LOCK, HOLDOFF, RUN.
- RESET -> WAIT_LOCK on the first edge after rst_n deasserts.
- WAIT_LOCK -> HOLDOFF when lock_s is 1.
- HOLDOFF -> RUN when the holdoff counter reaches LOCK_HOLDOFF-1.
- HOLDOFF or RUN -> WAIT_LOCK when lock_s is 0.
REQ-018 SHALL clear the holdoff counter on every entry to WAIT_LOCK; the counter increments by 1 per cycle only in HOLDOFF.
REQ-019 SHALL drive ready as a registered output that is 1 exactly while in RUN.
REQ-020 SHALL, in RUN, update each channel as {carry, acc[i]} <= acc[i] + inc[i], computed ACC_W+1 bits wide, with wrap modulo 2^ACC_W.
REQ-021 SHALL register carry into ce[i], so ce[i] pulses the cycle after the wrapping addition; mean rate = f_refclk * inc[i] / 2^ACC_W.
REQ-022 SHALL hold all accumulators at 0 and ce at 0 outside RUN.
REQ-023 SHALL give the first RUN-cycle addition a base of 0.
REQ-024 SHALL, on phase_rst=1, load every acc to 0 on that edge; ce for that cycle SHALL be 0, and accumulation SHALL resume on the next edge.
REQ-025 SHALL never produce a ce pulse on a channel whose inc is 0.
REQ-026 SHALL, on inc_wr=1 with inc_sel<CHANNELS, load inc[inc_sel] <= inc_data on that edge; the new value is used from the following addition.
REQ-027 SHALL, on inc_wr=1 with inc_sel>=CHANNELS, leave all inc unchanged and pulse inc_err.
REQ-028 SHALL pulse inc_ack for exactly one cycle, the cycle after each inc_wr cycle.
REQ-029 SHALL accept back-to-back inc_wr with one ack per write; no write is dropped.
REQ-030 SHALL accept increment writes in any state; lock loss SHALL not affect inc registers or ack generation.
REQ-031 SHALL, when phase_rst and inc_wr coincide, take both: accumulators zero, the new inc is used from the next addition.
REQ-032 SHALL, when lock_s falls in RUN, drive ready=0, ce=0 and acc=0 on the next edge, with no partial pulse.

Reset
REQ-033 SHALL, while rst_n=0, hold state=RESET, sync flops=0, holdoff counter=0, acc=0, inc[i]=INC_INIT, ce=0, ready=0, inc_ack=0, inc_err=0.
REQ-034 SHALL, on rst_n asserting mid-operation, clear all outputs asynchronously with no further ce pulses.

Verification
REQ-035 SHALL check lock qualification: LOCK_HOLDOFF=16, pll_locked rises -> ready rises 2 (sync) + 1 (WAIT_LOCK) + 16 cycles later; a pll_locked low glitch at cycle 10 of HOLDOFF -> counter restarts and ready stays 0.
REQ-036 SHALL check divide ratios with ACC_W=8 in RUN: inc=0x40 -> ce every 4th cycle; inc=0x80 -> every 2nd; inc=0xFF -> 255 pulses per 256 cycles; inc=0 -> no pulses over 1000 cycles.
REQ-037 SHALL check increment writes: inc_wr with inc_sel=1, inc_data=0x20 -> inc_ack one cycle later, channel 1 period becomes 8; inc_sel=7 with CHANNELS=4 -> inc_ack and inc_err pulse, no channel changes.
REQ-038 SHALL check phase_rst with channels 0 and 1 at inc=0x40 and 0x20 mid-run -> both first ce pulses thereafter are phase-aligned (4 and 8 cycles after resume).
REQ-039 SHALL check mid-RUN lock loss -> ready=0, ce=0 next edge; rst_n pulse mid-RUN -> all outputs 0 immediately and inc reverts to INC_INIT.
